// File: rtl/regfile_pkg.sv
// Shared types for the register storage: controller states and address-width helper.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  function automatic int addr_w(input int size);
    return (size > 2) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/regfile_bank.sv
// One storage bank: single write port, single registered read port, no reset so it maps to block RAM.
module regfile_bank #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 32,
  parameter int AW    = 5
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [SIZE];

  // Read-before-write on a same-address collision; the top handles bypass.
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/regfile_mem.sv
// Multi-read-port register storage: one bank per read port sharing a write stream,
// hardware clear after reset, and registered zero/range/bypass overrides per port.
module regfile_mem
  import regfile_pkg::*;
#(
  parameter int  WIDTH    = 32,
  parameter int  SIZE     = 32,
  parameter int  NUM_READ = 2,
  parameter bit  ZERO_REG = 1'b1,
  parameter bit  BYPASS   = 1'b1,
  localparam int AW       = addr_w(SIZE)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic [AW-1:0]             wr_addr,
  input  logic                      wr_en,
  input  logic [NUM_READ*AW-1:0]    rd_addr,
  output logic [NUM_READ*WIDTH-1:0] rd_data,
  output logic                      ready
);

  state_e        state, state_n;
  logic [AW-1:0] clr_ptr, clr_ptr_n;
  logic          ready_n;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      ready   <= 1'b0;
    end else begin
      state   <= state_n;
      clr_ptr <= clr_ptr_n;
      ready   <= ready_n;
    end
  end

  // Pointer holds at SIZE-1 on the last clear edge so it never wraps.
  always_comb begin
    state_n   = state;
    clr_ptr_n = clr_ptr;
    ready_n   = ready;
    case (state)
      CLEAR: begin
        if (clr_ptr == AW'(SIZE - 1)) begin
          state_n = READY;
          ready_n = 1'b1;
        end else begin
          clr_ptr_n = clr_ptr + 1'b1;
        end
      end
      READY: ;
      default: state_n = CLEAR;
    endcase
  end

  logic wr_in_range;
  if (SIZE == (1 << AW)) begin : g_wr_full
    assign wr_in_range = 1'b1;
  end else begin : g_wr_part
    assign wr_in_range = ({1'b0, wr_addr} < (AW+1)'(SIZE));
  end

  logic             wr_acc, bank_we;
  logic [AW-1:0]    bank_wa;
  logic [WIDTH-1:0] bank_wd;

  assign wr_acc  = (state == READY) && wr_en && wr_in_range && !(ZERO_REG && wr_addr == '0);
  assign bank_we = (state == CLEAR) || wr_acc;
  assign bank_wa = (state == CLEAR) ? clr_ptr : wr_addr;
  assign bank_wd = (state == CLEAR) ? '0 : wr_data;

  for (genvar i = 0; i < NUM_READ; i++) begin : g_port
    logic [AW-1:0]    ra;
    logic             rd_in_range;
    logic [WIDTH-1:0] raw, ovr_val;
    logic             ovr;

    assign ra = rd_addr[i*AW +: AW];

    if (SIZE == (1 << AW)) begin : g_rd_full
      assign rd_in_range = 1'b1;
    end else begin : g_rd_part
      assign rd_in_range = ({1'b0, ra} < (AW+1)'(SIZE));
    end

    regfile_bank #(.WIDTH(WIDTH), .SIZE(SIZE), .AW(AW)) u_bank (
      .CLK   (CLK),
      .we    (bank_we),
      .waddr (bank_wa),
      .wdata (bank_wd),
      .raddr (ra),
      .rdata (raw)
    );

    // Override decided alongside the bank read and applied after the bank register.
    always_ff @(posedge CLK) begin
      if (RST || state == CLEAR) begin
        ovr     <= 1'b1;
        ovr_val <= '0;
      end else if ((ZERO_REG && ra == '0) || !rd_in_range) begin
        ovr     <= 1'b1;
        ovr_val <= '0;
      end else if (BYPASS && wr_acc && wr_addr == ra) begin
        ovr     <= 1'b1;
        ovr_val <= wr_data;
      end else begin
        ovr     <= 1'b0;
        ovr_val <= '0;
      end
    end

    assign rd_data[i*WIDTH +: WIDTH] = ovr ? ovr_val : raw;
  end

endmodule

// File: tb/tb_regfile_mem.sv
// Bench: two configurations (32 entries zero-reg+bypass; 24 entries plain) fed the same stimulus
// and checked every edge against an array-based reference model.
module tb_regfile_mem;

  logic        CLK = 1'b0;
  logic        RST;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [4:0]  wr_addr;
  logic [9:0]  rd_addr;
  logic [63:0] rd_a, rd_b;
  logic        rdy_a, rdy_b;

  always #5 CLK = ~CLK;

  regfile_mem dut_a (
    .CLK(CLK), .RST(RST), .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
    .rd_addr(rd_addr), .rd_data(rd_a), .ready(rdy_a)
  );

  regfile_mem #(.SIZE(24), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
    .CLK(CLK), .RST(RST), .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
    .rd_addr(rd_addr), .rd_data(rd_b), .ready(rdy_b)
  );

  int n_chk = 0;
  int n_err = 0;

  // reference model state per configuration
  int          sz_c [2] = '{32, 24};
  bit          zr_c [2] = '{1'b1, 1'b0};
  bit          bp_c [2] = '{1'b1, 1'b0};
  logic [31:0] mem_m [2][32];
  bit          rdy_m [2] = '{1'b0, 1'b0};
  int          clr_m [2] = '{0, 0};
  logic [31:0] exp_rd [2][2];
  logic        exp_rdy [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < 2; c++) begin
      if (RST) begin
        rdy_m[c] = 1'b0;
        clr_m[c] = 0;
        for (int p = 0; p < 2; p++) exp_rd[c][p] = '0;
      end else if (!rdy_m[c]) begin
        clr_m[c]++;
        for (int p = 0; p < 2; p++) exp_rd[c][p] = '0;
        if (clr_m[c] == sz_c[c]) begin
          rdy_m[c] = 1'b1;
          for (int a = 0; a < 32; a++) mem_m[c][a] = '0;
        end
      end else begin
        int  wa;
        bit  acc;
        wa  = int'(wr_addr);
        acc = wr_en && (wa < sz_c[c]) && !(zr_c[c] && wa == 0);
        for (int p = 0; p < 2; p++) begin
          int ra;
          ra = int'(rd_addr[p*5 +: 5]);
          if (zr_c[c] && ra == 0)        exp_rd[c][p] = '0;
          else if (ra >= sz_c[c])        exp_rd[c][p] = '0;
          else if (acc && wa == ra && bp_c[c]) exp_rd[c][p] = wr_data;
          else                           exp_rd[c][p] = mem_m[c][ra];
        end
        if (acc) mem_m[c][wa] = wr_data;
      end
      exp_rdy[c] = rdy_m[c];
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge CLK);
    #1;
    for (int c = 0; c < 2; c++) begin
      logic [63:0] rd;
      logic        rdy;
      rd  = c ? rd_b : rd_a;
      rdy = c ? rdy_b : rdy_a;
      chk($sformatf("%s.%s.ready", tag, c ? "b" : "a"), {31'b0, rdy}, {31'b0, exp_rdy[c]});
      for (int p = 0; p < 2; p++)
        chk($sformatf("%s.%s.rd%0d", tag, c ? "b" : "a", p), rd[p*32 +: 32], exp_rd[c][p]);
    end
  endtask

  task automatic drive(input logic rst, input logic we, input int wa, input logic [31:0] wd,
                       input int ra0, input int ra1);
    RST     = rst;
    wr_en   = we;
    wr_addr = 5'(wa);
    wr_data = wd;
    rd_addr = {5'(ra1), 5'(ra0)};
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 32; a += 2) begin
      drive(0, 0, 0, 0, a, a + 1);
      step(tag);
    end
  endtask

  task automatic clear_run(input string tag);
    for (int k = 0; k < 32; k++) begin
      drive(0, 1, 5, 32'hDEADBEEF, int'($urandom_range(31)), int'($urandom_range(31)));
      step(tag);
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0);
    step("rst");
    step("rst");
    clear_run("clr");
    read_all("rdall");

    drive(0, 1, 3, 32'h12345678, 1, 2); step("wr3");
    drive(0, 0, 0, 0, 3, 3);            step("rd3");

    drive(0, 1, 0, 32'hFFFFFFFF, 4, 4); step("wr0");
    drive(0, 0, 0, 0, 0, 0);            step("rd0");

    drive(0, 1, 7, 32'hA, 1, 1);        step("wr7a");
    drive(0, 1, 7, 32'hB, 7, 7);        step("coll");
    drive(0, 0, 0, 0, 7, 7);            step("rd7");

    drive(0, 1, 30, 32'h5555AAAA, 5, 23); step("wr30");
    drive(0, 0, 0, 0, 30, 23);            step("rd30");
    read_all("oor");

    for (int k = 0; k < 400; k++) begin
      logic rst;
      rst = ($urandom_range(99) == 0);
      drive(rst, $urandom_range(1) == 1, int'($urandom_range(31)), $urandom,
            int'($urandom_range(31)), int'($urandom_range(31)));
      step("rnd");
    end
    drive(1, 0, 0, 0, 0, 0); step("rst2");
    clear_run("clr2");

    for (int k = 0; k < 40; k++) begin
      drive(0, 1, int'($urandom_range(31)), $urandom, int'($urandom_range(31)),
            int'($urandom_range(31)));
      step("fill");
    end
    drive(1, 0, 0, 0, 0, 0); step("rst_rdy");
    clear_run("clr3");
    read_all("rdall3");

    drive(1, 0, 0, 0, 0, 0); step("rst4");
    for (int k = 0; k < 10; k++) begin
      drive(0, 1, 5, 32'hDEADBEEF, 3, 5);
      step("clr10");
    end
    drive(1, 0, 0, 0, 0, 0); step("rst_clr");
    clear_run("clr4");
    read_all("rdall4");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
